// File: rtl/calc_seq_pkg.sv
// ----------------------------------------------------------------------------
// calc_seq_pkg
//
// Shared types and constants for the calculator program sequencer.
//   opcode_t : operation selected by the low nibble of an opcode byte.
//   state_t  : sequencer FSM states.
//   OPC_W    : width of the decoded opcode field.
//   PC_W     : width of the program counter (128-entry command SRAM).
//
// Both enums would otherwise share the name HALT, so opcode members carry
// an OP_ prefix and state members an ST_ prefix.
// ----------------------------------------------------------------------------
package calc_seq_pkg;

    localparam int OPC_W = 4;
    localparam int PC_W  = 7;

    typedef enum logic [OPC_W-1:0] {
        OP_HALT = 4'd0,
        OP_LDI  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_LDM  = 4'd4,
        OP_STM  = 4'd5,
        OP_JNZ  = 4'd6
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_FETCH_ARG = 3'd2,
        ST_EXEC      = 3'd3,
        ST_MEM_RD    = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

endpackage

// File: rtl/calc_alu.sv
// ----------------------------------------------------------------------------
// calc_alu
//
// Purely combinational accumulator update for one instruction.
//   i_opcode     : decoded opcode (low nibble of the opcode byte)
//   i_acc        : current accumulator
//   i_operand    : operand byte
//   o_acc_next   : accumulator after the operation (modulo 256)
//   o_illegal    : opcode is outside the defined set (7..15)
//
// Operations that do not change the accumulator here (HALT, LDM, STM, JNZ
// and illegal codes) pass i_acc through; LDM's value arrives later from the
// SRAM and is handled by the sequencer.
// ----------------------------------------------------------------------------
module calc_alu
    import calc_seq_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    input  logic [7:0]       i_acc,
    input  logic [7:0]       i_operand,
    output logic [7:0]       o_acc_next,
    output logic             o_illegal
);

    always_comb begin
        o_acc_next = i_acc;
        o_illegal  = 1'b0;
        case (i_opcode)
            OP_LDI:  o_acc_next = i_operand;
            OP_ADD:  o_acc_next = i_acc + i_operand;   // carry dropped
            OP_SUB:  o_acc_next = i_acc - i_operand;   // borrow dropped
            OP_HALT, OP_LDM, OP_STM, OP_JNZ: o_acc_next = i_acc;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// ----------------------------------------------------------------------------
// calc_sequencer
//
// Fetches {opcode, operand} byte pairs from the 128x8 command SRAM, runs
// them against an 8-bit accumulator and writes STM results back. Sole
// master of the SRAM ports while a run is in progress.
//
// Parameters
//   START_ADDR : program counter value on reset and on every start (0..127)
//   MAX_STEPS  : instruction-count watchdog limit (1..255)
//
// Ports
//   clk, reset   : clock, asynchronous active-high reset
//   start        : begin a run (honoured in IDLE and HALT only)
//   readReg      : SRAM read address (combinational from state, bit 7 = 0)
//   readData     : SRAM combinational read data
//   writeReg     : SRAM write address (bit 7 = 0)
//   writeData    : SRAM write data
//   regWrite     : SRAM write strobe, one cycle in EXEC of STM
//   acc          : accumulator
//   pc           : program counter
//   busy         : run in progress (FETCH_OP, FETCH_ARG, EXEC, MEM_RD)
//   done         : level, high in HALT
//   error        : illegal opcode or watchdog expiry; valid while done
//   o_dbg_state  : current FSM state, for observation only
//
// Handshake: start is a level sampled on the rising edge; done/error are
// levels held until the next start or reset.
//
// Latency: three cycles per instruction (FETCH_OP, FETCH_ARG, EXEC), four
// for LDM (extra MEM_RD). HALT and illegal opcodes are not counted steps.
// ----------------------------------------------------------------------------
module calc_sequencer
    import calc_seq_pkg::*;
#(
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned MAX_STEPS  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [7:0]       readReg,
    input  logic [7:0]       readData,
    output logic [7:0]       writeReg,
    output logic [7:0]       writeData,
    output logic             regWrite,
    output logic [7:0]       acc,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             done,
    output logic             error,
    output state_t           o_dbg_state
);

    localparam logic [PC_W-1:0] START_PC  = PC_W'(START_ADDR);
    localparam logic [7:0]      STEP_LIM  = 8'(MAX_STEPS);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [7:0]        r_acc;
    logic [OPC_W-1:0]  r_opcode;
    logic [7:0]        r_operand;
    logic [7:0]        r_steps;
    logic              r_error;

    // ------------------------------------------------------------------
    // Next-state / output wires
    // ------------------------------------------------------------------
    state_t            w_state_next;
    logic [PC_W-1:0]   w_pc_next;
    logic [7:0]        w_acc_next;
    logic [OPC_W-1:0]  w_opcode_next;
    logic [7:0]        w_operand_next;
    logic [7:0]        w_steps_next;
    logic              w_error_next;
    logic [PC_W-1:0]   w_read_addr;
    logic [PC_W-1:0]   w_write_addr;
    logic [7:0]        w_write_data;
    logic              w_reg_write;
    logic              w_step_done;
    logic [7:0]        w_steps_inc;
    logic [7:0]        w_alu_acc;
    logic              w_alu_illegal;

    calc_alu u_alu (
        .i_opcode   (r_opcode),
        .i_acc      (r_acc),
        .i_operand  (r_operand),
        .o_acc_next (w_alu_acc),
        .o_illegal  (w_alu_illegal)
    );

    assign w_steps_inc = r_steps + 8'd1;

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= START_PC;
            r_acc     <= 8'd0;
            r_opcode  <= '0;
            r_operand <= 8'd0;
            r_steps   <= 8'd0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_acc     <= w_acc_next;
            r_opcode  <= w_opcode_next;
            r_operand <= w_operand_next;
            r_steps   <= w_steps_next;
            r_error   <= w_error_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and SRAM port logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_acc_next     = r_acc;
        w_opcode_next  = r_opcode;
        w_operand_next = r_operand;
        w_steps_next   = r_steps;
        w_error_next   = r_error;
        w_read_addr    = '0;
        w_write_addr   = '0;
        w_write_data   = 8'd0;
        w_reg_write    = 1'b0;
        w_step_done    = 1'b0;

        unique case (r_state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    w_state_next = ST_FETCH_OP;
                    w_pc_next    = START_PC;
                    w_steps_next = 8'd0;
                    w_error_next = 1'b0;
                end
            end

            ST_FETCH_OP: begin
                // High nibble of the opcode byte is deliberately dropped.
                w_read_addr   = r_pc;
                w_opcode_next = readData[OPC_W-1:0];
                w_pc_next     = r_pc + 1'b1;
                w_state_next  = ST_FETCH_ARG;
            end

            ST_FETCH_ARG: begin
                w_read_addr    = r_pc;
                w_operand_next = readData;
                w_pc_next      = r_pc + 1'b1;
                w_state_next   = ST_EXEC;
            end

            ST_EXEC: begin
                if (r_opcode == OP_HALT) begin
                    w_state_next = ST_HALT;
                end else if (r_opcode == OP_LDM) begin
                    w_state_next = ST_MEM_RD;
                end else if (w_alu_illegal) begin
                    w_error_next = 1'b1;
                    w_state_next = ST_HALT;
                end else begin
                    w_acc_next  = w_alu_acc;
                    w_step_done = 1'b1;
                    if (r_opcode == OP_STM) begin
                        w_reg_write  = 1'b1;
                        w_write_addr = r_operand[PC_W-1:0];
                        w_write_data = r_acc;
                    end
                    if (r_opcode == OP_JNZ && r_acc != 8'd0) begin
                        w_pc_next = r_operand[PC_W-1:0];
                    end
                end
            end

            ST_MEM_RD: begin
                w_read_addr = r_operand[PC_W-1:0];
                w_acc_next  = readData;
                w_step_done = 1'b1;
            end

            default: w_state_next = ST_IDLE;
        endcase

        // Shared step accounting for EXEC and MEM_RD completions.
        if (w_step_done) begin
            w_steps_next = w_steps_inc;
            if (w_steps_inc == STEP_LIM) begin
                w_error_next = 1'b1;
                w_state_next = ST_HALT;
            end else begin
                w_state_next = ST_FETCH_OP;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign readReg     = {1'b0, w_read_addr};
    assign writeReg    = {1'b0, w_write_addr};
    assign writeData   = w_write_data;
    assign regWrite    = w_reg_write;
    assign acc         = r_acc;
    assign pc          = r_pc;
    assign busy        = (r_state == ST_FETCH_OP) || (r_state == ST_FETCH_ARG) ||
                         (r_state == ST_EXEC)     || (r_state == ST_MEM_RD);
    assign done        = (r_state == ST_HALT);
    assign error       = r_error;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_calc_sequencer
//
// Directed programs from the test plan followed by random programs, each
// checked against an instruction-level reference model that executes the
// program on its own copy of the SRAM.
// ----------------------------------------------------------------------------
module tb_calc_sequencer;
    import calc_seq_pkg::*;

    localparam int START_ADDR = 0;
    localparam int MAX_STEPS  = 10;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] readReg, readData, writeReg, writeData, acc;
    logic       regWrite, busy, done, error;
    logic [6:0] pc;
    state_t     dbg_state;

    always #5 clk = ~clk;

    calc_sequencer #(.START_ADDR(START_ADDR), .MAX_STEPS(MAX_STEPS)) dut (
        .clk(clk), .reset(reset), .start(start),
        .readReg(readReg), .readData(readData),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .acc(acc), .pc(pc), .busy(busy), .done(done), .error(error),
        .o_dbg_state(dbg_state)
    );

    // ---------------- SRAM model ----------------
    logic [7:0] mem [128];
    logic [7:0] img [128];
    logic       load_en = 1'b0;

    assign readData = mem[readReg[6:0]];

    always @(posedge clk) begin
        if (load_en) mem <= img;
        else if (regWrite) mem[writeReg[6:0]] <= writeData;
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_wr     = 0;
    bit          mon_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset && regWrite) begin
            n_wr++;
            if (exp_q.size() == 0) check("wr_unexpected", {writeReg, writeData}, 16'hxxxx);
            else check("wr_addr_data", {writeReg, writeData}, exp_q.pop_front());
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] m_mem [128];
    logic [7:0] m_acc = 8'd0;
    logic       m_err;
    logic [6:0] m_pc;
    int         m_cycles;
    int         last_cycles;

    task automatic model_run();
        logic [6:0] p;
        logic [7:0] op, arg;
        int         steps;
        bit         fin;
        p = 7'(START_ADDR); steps = 0; m_err = 1'b0; m_cycles = 0; fin = 1'b0;
        while (!fin) begin
            op = m_mem[p]; p = p + 7'd1;
            arg = m_mem[p]; p = p + 7'd1;
            m_cycles += 3;
            case (op[3:0])
                4'd0: fin = 1'b1;
                4'd1: m_acc = arg;
                4'd2: m_acc = m_acc + arg;
                4'd3: m_acc = m_acc - arg;
                4'd4: begin m_acc = m_mem[arg[6:0]]; m_cycles += 1; end
                4'd5: begin
                    m_mem[arg[6:0]] = m_acc;
                    exp_q.push_back({1'b0, arg[6:0], m_acc});
                end
                4'd6: if (m_acc != 8'd0) p = arg[6:0];
                default: begin m_err = 1'b1; fin = 1'b1; end
            endcase
            if (!fin) begin
                steps++;
                if (steps == MAX_STEPS) begin m_err = 1'b1; fin = 1'b1; end
            end
        end
        m_pc = p;
    endtask

    // ---------------- driver tasks ----------------
    logic [7:0] pq[$];

    task automatic load_img();
        @(negedge clk); load_en = 1'b1;
        @(posedge clk); #1 load_en = 1'b0;
    endtask

    task automatic set_prog();
        foreach (img[i]) img[i] = 8'h00;
        foreach (pq[i]) img[(START_ADDR + i) % 128] = pq[i];
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // busy_poke > 0 raises start for one cycle that many cycles into the run
    task automatic run_prog(input int busy_poke);
        int cyc;
        int bad;
        load_img();
        foreach (m_mem[i]) m_mem[i] = img[i];
        exp_q.delete(); n_wr = 0;
        model_run();
        pulse_start();
        cyc = 0;
        while (!done && cyc < 300) begin
            start = (busy_poke > 0 && cyc == busy_poke);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        last_cycles = cyc;
        check("done_timeout", {31'd0, done}, 32'd1);
        check("cycles", cyc, m_cycles);
        check("acc", acc, m_acc);
        check("error", error, m_err);
        check("busy_at_halt", busy, 1'b0);
        check("pc_final", pc, m_pc);
        check("writes_left", exp_q.size(), 0);
        check("halt_rd_addr", readReg, 8'd0);
        check("halt_wr_bus", {writeReg, writeData, 7'd0, regWrite}, 24'd0);
        bad = 0;
        foreach (mem[i]) if (mem[i] !== m_mem[i]) bad++;
        check("mem_image", bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_acc"}, acc, 8'd0);
        check({tag, "_pc"}, pc, 7'(START_ADDR));
        check({tag, "_flags"}, {busy, done, error, regWrite}, 4'b0000);
        check({tag, "_buses"}, {readReg, writeReg, writeData}, 24'd0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        logic [3:0] sel;
        reset = 1'b1; start = 1'b0;
        foreach (img[i]) img[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) reset = 1'b0;
        mon_en = 1'b1;

        // LDI 05; ADD 03; HALT
        pq = {8'h01, 8'h05, 8'h02, 8'h03, 8'h00, 8'h00};
        set_prog(); run_prog(0);
        check("ldi_add_acc", acc, 8'h08);
        check("ldi_add_latency", last_cycles, 9);

        // modulo-256 arithmetic
        pq = {8'h01, 8'hFF, 8'h02, 8'h02, 8'h03, 8'h05, 8'h00, 8'h00};
        set_prog(); run_prog(0);
        check("wrap_acc", acc, 8'hFC);

        // STM then LDM of the same address
        pq = {8'h01, 8'h2A, 8'h05, 8'h50, 8'h01, 8'h00, 8'h04, 8'h50, 8'h00, 8'h00};
        set_prog(); run_prog(0);
        check("mem_acc", acc, 8'h2A);
        check("mem_wr_count", n_wr, 1);
        check("mem_written", mem[8'h50], 8'h2A);

        // countdown loop, with start raised while busy
        pq = {8'h01, 8'h03, 8'h03, 8'h01, 8'h06, 8'h02, 8'h00, 8'h00};
        set_prog(); run_prog(5);
        check("loop_acc", acc, 8'h00);
        check("loop_error", error, 1'b0);
        check("loop_cycles", last_cycles, 7 * 3 + 3);

        // illegal opcode with a non-zero high nibble
        pq = {8'h01, 8'h11, 8'hA9, 8'h00, 8'h00, 8'h00};
        set_prog(); run_prog(0);
        check("illegal_error", error, 1'b1);

        // watchdog: acc = 1 carried over, then JNZ 00 forever
        pq = {8'h01, 8'h01, 8'h00, 8'h00};
        set_prog(); run_prog(0);
        pq = {8'h06, 8'h00};
        set_prog(); run_prog(0);
        check("watchdog_error", error, 1'b1);
        check("watchdog_cycles", last_cycles, MAX_STEPS * 3);

        // reset while STM is writing
        pq = {8'h01, 8'h2A, 8'h05, 8'h50, 8'h00, 8'h00};
        set_prog(); img[8'h50] = 8'h11;
        load_img();
        mon_en = 1'b0;
        pulse_start();
        waited = 0;
        while (!regWrite && waited < 20) begin
            @(negedge clk); waited++;
        end
        check("rst_stm_seen", regWrite, 1'b1);
        #1 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        check("rst_no_write", mem[8'h50], 8'h11);
        @(negedge clk) reset = 1'b0;
        m_acc = 8'd0;
        mon_en = 1'b1;
        run_prog(0);
        check("after_rst_acc", acc, 8'h2A);

        // random programs
        for (int t = 0; t < 40; t++) begin
            foreach (img[i]) img[i] = 8'($urandom);
            for (int a = 0; a < 40; a += 2) begin
                sel = 4'($urandom_range(0, 15));
                if (sel == 0) img[a][3:0] = 4'd0;
                else if (sel == 1) img[a][3:0] = 4'($urandom_range(7, 15));
                else img[a][3:0] = 4'($urandom_range(1, 6));
                if (img[a][3:0] == 4'd6) img[a+1] = 8'($urandom_range(0, 19) * 2);
            end
            run_prog((t % 4 == 0) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
